// File: rtl/prbs7_stream_checker.sv
// Serial PRBS7 (x^7+x^6+1) checker: fills, hunts for lock, then counts errors against
// a free-running local generator.
//
// state  | meaning
// FILL   | loading seven received bits into the shift register
// HUNT   | counting consecutive predicted matches towards lock
// LOCKED | generator free-runs; mismatches counted, bursts drop lock
module prbs7_stream_checker #(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [5:0]       LOCK_RUN = 6'(LOCK_CNT);
  localparam logic [5:0]       LOSS_RUN = 6'(LOSS_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [6:0]       sr_q, sr_d;
  logic [5:0]       run_q, run_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic       pred;
  logic       match;
  logic [5:0] run_inc;
  logic       err_inc;
  logic       bit_inc;

  assign pred    = sr_q[6] ^ sr_q[5];
  assign match   = ~(din ^ pred);
  assign run_inc = run_q + 6'd1;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    run_d       = run_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    bit_inc     = 1'b0;
    if (din_vld) begin
      case (state_q)
        FILL: begin
          sr_d = {sr_q[5:0], din};
          if (run_q == 6'd6) begin
            run_d   = 6'd0;
            state_d = HUNT;
          end else begin
            run_d = run_inc;
          end
        end
        HUNT: begin
          sr_d = {sr_q[5:0], din};
          // an all-zero register predicts zero forever, so it never counts as a match
          if (match && (sr_q != 7'd0)) begin
            if (run_inc == LOCK_RUN) begin
              run_d   = 6'd0;
              state_d = LOCKED;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = 6'd0;
          end
        end
        LOCKED: begin
          sr_d    = {sr_q[5:0], pred};
          bit_inc = 1'b1;
          if (!match) begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            if (run_inc == LOSS_RUN) begin
              run_d   = 6'd0;
              state_d = FILL;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = 6'd0;
          end
        end
        default: begin
          state_d = FILL;
          run_d   = 6'd0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);

    err_cnt_d = err_cnt_q;
    if (clr)                                err_cnt_d = '0;
    else if (err_inc && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;

    bit_cnt_d = bit_cnt_q;
    if (clr)                                bit_cnt_d = '0;
    else if (bit_inc && bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      sr_q        <= 7'd0;
      run_q       <= 6'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_prbs7_stream_checker.sv
// Scoreboard bench for prbs7_stream_checker: the driver queues the expected outputs per
// valid bit, a monitor pops and compares them one edge later.
module tb_prbs7_stream_checker;

  localparam int LOCK_LAT = 15;  // 7 fill bits + 8 matches
  localparam int LOSS     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_vld = 1'b0;
  logic        clr = 1'b0;

  logic        locked, err_pulse;
  logic [15:0] err_cnt, bit_cnt;
  logic        locked4, err_pulse4;
  logic [3:0]  err_cnt4, bit_cnt4;

  prbs7_stream_checker dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  prbs7_stream_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .clr(clr),
    .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .bit_cnt(bit_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lock;
    logic pulse;
    int   err;
    int   bits;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic       exp_lock;
  int         exp_err, exp_bit, acq, miss, gap;
  logic [6:0] gen;
  logic       mon_vld;

  task automatic check1(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // monitor: one output set per consumed bit, err_pulse must be quiet otherwise
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      mon_vld = din_vld && rst_n;
      #1;
      if (mon_vld) begin
        if (q.size() == 0) begin
          check1("scoreboard_underflow", 0, 1);
        end else begin
          e = q.pop_front();
          check1("locked",     int'(locked),     int'(e.lock));
          check1("err_pulse",  int'(err_pulse),  int'(e.pulse));
          check1("err_cnt",    int'(err_cnt),    e.err);
          check1("bit_cnt",    int'(bit_cnt),    e.bits);
          check1("locked_w4",  int'(locked4),    int'(e.lock));
          check1("err_cnt_w4", int'(err_cnt4),   sat4(e.err));
          check1("bit_cnt_w4", int'(bit_cnt4),   sat4(e.bits));
        end
      end else if (rst_n) begin
        check1("idle_pulse", int'(err_pulse), 0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_vld = 1'b0;
      clr     = 1'b0;
      din     = 1'b0;
    end
  endtask

  // next true PRBS bit, optionally inverted on the line, with the expected outcome
  task automatic send(input logic flip, input logic c);
    logic t;
    exp_t e;
    t   = gen[6] ^ gen[5];
    gen = {gen[5:0], t};
    e.pulse = 1'b0;
    if (exp_lock) begin
      exp_bit++;
      if (flip) begin
        e.pulse = 1'b1;
        exp_err++;
        miss++;
        if (miss == LOSS) begin
          exp_lock = 1'b0;
          acq      = 0;
          miss     = 0;
        end
      end else begin
        miss = 0;
      end
    end else begin
      acq++;
      if (acq == LOCK_LAT) exp_lock = 1'b1;
    end
    if (c) begin
      exp_err = 0;
      exp_bit = 0;
    end
    e.lock = exp_lock;
    e.err  = exp_err;
    e.bits = exp_bit;
    @(negedge clk);
    din     = t ^ flip;
    din_vld = 1'b1;
    clr     = c;
    q.push_back(e);
    repeat (gap) begin
      @(negedge clk);
      din_vld = 1'b0;
      clr     = 1'b0;
      din     = 1'b0;
    end
  endtask

  task automatic send_zero();
    exp_t e;
    e.lock = 1'b0; e.pulse = 1'b0; e.err = 0; e.bits = 0;
    @(negedge clk);
    din     = 1'b0;
    din_vld = 1'b1;
    clr     = 1'b0;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    din_vld = 1'b0;
    clr     = 1'b0;
    din     = 1'b0;
    @(posedge clk);
    #1;
    check1("rst_locked",    int'(locked),    0);
    check1("rst_err_pulse", int'(err_pulse), 0);
    check1("rst_err_cnt",   int'(err_cnt),   0);
    check1("rst_bit_cnt",   int'(bit_cnt),   0);
    check1("rst_locked_w4", int'(locked4),   0);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_lock = 1'b0;
    exp_err  = 0;
    exp_bit  = 0;
    acq      = 0;
    miss     = 0;
    gen      = 7'h7F;
  endtask

  initial begin
    gap = 0;
    do_reset();

    // clean stream: lock after bit 15, then 254 counted bits with no errors
    repeat (LOCK_LAT) send(1'b0, 1'b0);
    repeat (254) send(1'b0, 1'b0);
    idle(2);

    // single line error while locked
    send(1'b1, 1'b0);
    repeat (20) send(1'b0, 1'b0);
    idle(2);

    // clear counters, then a four-error burst drops lock and the clean stream relocks
    @(negedge clk);
    clr = 1'b1;
    exp_err = 0;
    exp_bit = 0;
    idle(1);
    repeat (LOSS) send(1'b1, 1'b0);
    repeat (LOCK_LAT) send(1'b0, 1'b0);
    repeat (10) send(1'b0, 1'b0);
    idle(2);

    // stuck-at-0 line never locks
    do_reset();
    repeat (200) send_zero();
    idle(3);

    // sparse valid (1 in 3), clr coincident with an error
    do_reset();
    gap = 2;
    repeat (LOCK_LAT) send(1'b0, 1'b0);
    repeat (10) send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    repeat (5) send(1'b0, 1'b0);

    // 20 isolated errors: 16-bit counter reaches 20, 4-bit counter holds at 15
    repeat (20) begin
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
    end

    // reset while locked, then relock from scratch
    do_reset();
    gap = 0;
    repeat (LOCK_LAT) send(1'b0, 1'b0);
    repeat (5) send(1'b0, 1'b0);
    idle(3);

    check1("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/prbs7_stream_checker.md
# prbs7_stream_checker

Serial PRBS7 checker that sits directly downstream of the my_module two-flop datapath and consumes its 1-bit `out` stream. It acquires lock to an x^7+x^6+1 sequence, then compares each received bit against a free-running local generator. It counts bit errors and valid bits while locked, and drops lock on a burst of consecutive mismatches. It is used as the on-chip pass/fail monitor for the timing-characterisation design.

## Interface
Parameters:
- `LOCK_CNT`, default 8: consecutive matches required in HUNT to declare lock (legal range 1..63).
- `LOSS_CNT`, default 4: consecutive mismatches in LOCKED that force loss of lock (legal range 1..63).
- `CNT_W`, default 16: width of `err_cnt` and `bit_cnt`.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `din`  in  1: serial data bit, driven by the upstream stage's `out`.
- `din_vld`  in  1: qualifies `din`; bits are consumed only when it is 1.
- `clr`  in  1: synchronous clear of `err_cnt` and `bit_cnt`; does not affect lock state.
- `locked`  out  1: checker is in LOCKED.
- `err_pulse`  out  1: one-cycle pulse per mismatched bit while locked.
- `err_cnt`  out  CNT_W: saturating error count.
- `bit_cnt`  out  CNT_W: saturating count of valid bits checked while locked.

## Operation
- Internal state:
  - `sr[6:0]`: shift register.
  - `pred = sr[6]^sr[5]`: predicted next bit.
  - `match = (din == pred)`.
  - `run` counter, 6 bits.
  - FSM with states FILL, HUNT, LOCKED.
- Nothing changes on cycles where `din_vld`=0, except reset and `clr`.
- **FILL:**
  - Each valid bit shifts in: `sr <= {sr[5:0], din}`; `run++`.
  - After the 7th valid bit, set `run`=0 and go to HUNT.
- **HUNT:**
  - Each valid bit shifts `din` into `sr`.
  - If `match` and `sr != 0`: `run++`. Otherwise `run`=0.
  - The all-zero `sr` case is always treated as a mismatch, so the checker never locks on a stuck-at-0 line.
  - When `run` reaches `LOCK_CNT`, go to LOCKED and set `run`=0.
- **LOCKED:**
  - Each valid bit shifts `pred` (not `din`) into `sr`, so the generator free-runs and one line error yields exactly one counted error.
  - `bit_cnt++`.
  - On mismatch: `err_pulse`=1, `err_cnt++`, `run++`.
  - On match: `run`=0.
  - When `run` reaches `LOSS_CNT`, go to FILL, set `run`=0, and deassert `locked`. The error that causes the loss is still counted.
- **Counters:** saturate at 2^CNT_W−1 and never wrap.
- **`clr`:**
  - Takes priority over a same-cycle increment: the counter becomes 0.
  - A same-cycle `err_pulse` still fires.
- **Reset:** a low `rst_n` at any edge, including mid-lock, forces:
  - state FILL, `sr`=0, `run`=0;
  - `locked`=0, `err_pulse`=0, `err_cnt`=0, `bit_cnt`=0.

## Timing
- All outputs are registered.
- A valid bit sampled at edge k is reflected in `err_pulse`, `err_cnt`, `bit_cnt` and `locked` immediately after edge k.
- `err_pulse` is high for exactly the one cycle following the erroneous bit's edge. It is 0 on invalid cycles.
- Lock acquisition on a clean stream: `locked` rises after the (7+LOCK_CNT)-th valid bit; that is the 15th with defaults.
- The bit that completes the lock is not counted in `bit_cnt`. Counting starts with the next valid bit.
- Loss of lock: `locked` falls after the LOSS_CNT-th consecutive mismatch.
- Re-lock needs a further 7+LOCK_CNT valid bits.
- `din_vld` gaps of any length are allowed. They stretch latency in cycles but not in valid bits.
- Combinational depth: `pred`/`match` (one XOR, one XNOR) plus counter increment must close at the clock period of the upstream stage.

## Test plan
- Clean PRBS7 (seed 7'h7F), `din_vld`=1 continuously, default parameters:
  - `locked` rises after bit 15.
  - After 254 further bits: `err_cnt`=0, `bit_cnt`=254.
- Once locked, flip a single bit:
  - exactly one `err_pulse`;
  - `err_cnt`=1;
  - `locked` stays 1.
- `din` stuck at 0 for 200 valid bits after reset: `locked` never asserts and `err_cnt`=0.
- Locked, then 4 consecutive flipped bits followed by a clean stream:
  - `err_cnt`=4;
  - `locked` falls after the 4th flip;
  - `locked` re-asserts 15 valid bits later.
- `din_vld` high 1 cycle in 3; assert `clr` in the same cycle as a flipped bit:
  - lock point is still at valid bit 15;
  - `err_pulse`=1 and `err_cnt`=0 after that edge.
- `CNT_W`=4, locked, 20 isolated errors each separated by ≥1 match: `err_cnt` holds at 15 and `locked` stays 1.
- Reset mid-lock: assert `rst_n`=0 for 1 cycle while locked:
  - all outputs are 0 next cycle;
  - re-lock after 15 valid bits.
